// File: rtl/dac_sample_feeder.sv
// -----------------------------------------------------------------------------
// dac_sample_feeder
//
// Upstream feeder for dac_interface. Host-written 8-bit samples are buffered
// in a circular FIFO and paced out at a programmable sample period. Each pacer
// tick that finds the FIFO non-empty pops one sample and issues exactly one
// start/done handshake with the DAC. Ticks that find the FIFO empty, or that
// arrive while a transfer is still in flight, raise sticky flags.
//
// Parameters:
//   DEPTH     FIFO depth in samples (power of two, >= 2)
//   DIV_W     width of the sample-period counter
//
// Ports:
//   sclk       system clock (shared with dac_interface)
//   n_reset    asynchronous active-low reset
//   wr_en      push wr_data into the FIFO this cycle
//   wr_data    sample to push
//   enable     run the sample pacer
//   period     a tick occurs every period+1 enabled cycles
//   clr_flags  clear the sticky flags (a same-cycle set wins)
//   dac_done   one-cycle completion pulse from dac_interface
//   dac_data   sample presented to dac_interface
//   dac_start  one-cycle transfer request
//   full       FIFO holds DEPTH samples
//   empty      FIFO holds no samples
//   count      current FIFO occupancy
//   underrun   sticky: a tick found the FIFO empty
//   late       sticky: a tick arrived while a transfer was busy
// -----------------------------------------------------------------------------
module dac_sample_feeder #(
   parameter int DEPTH = 16,
   parameter int DIV_W = 16
) (
   input  logic                     sclk,
   input  logic                     n_reset,
   input  logic                     wr_en,
   input  logic [7:0]               wr_data,
   input  logic                     enable,
   input  logic [DIV_W-1:0]         period,
   input  logic                     clr_flags,
   input  logic                     dac_done,
   output logic [7:0]               dac_data,
   output logic                     dac_start,
   output logic                     full,
   output logic                     empty,
   output logic [$clog2(DEPTH):0]   count,
   output logic                     underrun,
   output logic                     late
);

   localparam int AW = $clog2(DEPTH);
   localparam logic [AW:0] DEPTH_CNT = (AW+1)'(DEPTH);

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      ISSUE = 2'd1,
      WAIT  = 2'd2
   } state_t;

   state_t           state;
   state_t           state_nxt;

   logic [7:0]       mem [DEPTH];
   logic [AW-1:0]    wr_ptr;
   logic [AW-1:0]    rd_ptr;
   logic [DIV_W-1:0] cnt;

   logic             tick;
   logic             pop;
   logic             push;

   assign full  = (count == DEPTH_CNT);
   assign empty = (count == '0);

   // Comparing with >= (not ==) means lowering period below the running count
   // still yields a tick on the next cycle instead of waiting for a wrap.
   assign tick = enable && (cnt >= period);

   // empty is the registered occupancy, so a push in the tick cycle cannot
   // satisfy that tick.
   assign pop  = tick && (state == IDLE) && !empty;

   // A full FIFO still accepts a push when the head leaves in the same cycle.
   assign push = wr_en && (!full || pop);

   // Sample storage carries no reset; discarding contents on reset is done
   // by clearing the pointers and occupancy.
   always_ff @(posedge sclk) begin
      if (push) begin
         mem[wr_ptr] <= wr_data;
      end
   end

   always_ff @(posedge sclk or negedge n_reset) begin
      if (!n_reset) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else begin
         if (push) begin
            wr_ptr <= wr_ptr + 1'b1;
         end
         if (pop) begin
            rd_ptr <= rd_ptr + 1'b1;
         end
         case ({push, pop})
            2'b10:   count <= count + 1'b1;
            2'b01:   count <= count - 1'b1;
            default: count <= count;
         endcase
      end
   end

   always_ff @(posedge sclk or negedge n_reset) begin
      if (!n_reset) begin
         cnt <= '0;
      end else if (!enable || tick) begin
         cnt <= '0;
      end else begin
         cnt <= cnt + 1'b1;
      end
   end

   // dac_data only moves on a pop, so it is held from dac_start to dac_done.
   always_ff @(posedge sclk or negedge n_reset) begin
      if (!n_reset) begin
         dac_data <= '0;
      end else if (pop) begin
         dac_data <= mem[rd_ptr];
      end
   end

   always_ff @(posedge sclk or negedge n_reset) begin
      if (!n_reset) begin
         state <= IDLE;
      end else begin
         state <= state_nxt;
      end
   end

   always_comb begin
      state_nxt = state;
      dac_start = 1'b0;
      case (state)
         IDLE: begin
            if (pop) begin
               state_nxt = ISSUE;
            end
         end
         ISSUE: begin
            dac_start = 1'b1;
            state_nxt = WAIT;
         end
         WAIT: begin
            if (dac_done) begin
               state_nxt = IDLE;
            end
         end
         default: begin
            state_nxt = IDLE;
         end
      endcase
   end

   // Sticky flags: a set condition in the same cycle as clr_flags wins.
   always_ff @(posedge sclk or negedge n_reset) begin
      if (!n_reset) begin
         underrun <= 1'b0;
         late     <= 1'b0;
      end else begin
         if (tick && (state == IDLE) && empty) begin
            underrun <= 1'b1;
         end else if (clr_flags) begin
            underrun <= 1'b0;
         end
         if (tick && (state != IDLE)) begin
            late <= 1'b1;
         end else if (clr_flags) begin
            late <= 1'b0;
         end
      end
   end

endmodule
